dma_priority_arbiter: RTL and testbench

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

---
 rtl/dma_priority_arbiter.sv | 148 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: picks one of four requesting channels, negotiates the
// bus with the CPU through HRQ/HLDA, then holds the grant until the transfer
// stage reports completion or the CPU takes the bus back. A programmable
// idle gap separates consecutive grants. Priority is either fixed (ch0 first)
// or rotating, in which case the channel just serviced drops to the bottom.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no grant pending; arbitrate among eligible channels
//   WAIT_HLDA | winner frozen, HRQ raised, waiting for the CPU to release
//   SERVICE   | DACK/CH_VALID/CH_SEL driven for the winner until TC or abort
//   GAP       | REARB_GAP idle cycles before the next arbitration

module dma_priority_arbiter #(
  parameter int unsigned REARB_GAP = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] MASK,
  input  logic       ROTATE,
  input  logic       HLDA,
  input  logic       TC_DONE,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       CH_VALID,
  output logic [1:0] CH_SEL
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HLDA,
    S_SERVICE,
    S_GAP
  } state_t;

  state_t     r_state;
  logic [1:0] r_winner;
  logic [1:0] r_prio_ptr;
  logic [3:0] r_gap_cnt;
  logic       r_hrq;
  logic [3:0] r_dack;
  logic       r_ch_valid;
  logic [1:0] r_ch_sel;

  logic [3:0] w_eligible;
  logic [1:0] w_base;
  logic [1:0] w_idx;
  logic [1:0] w_pick;
  logic       w_found;
  logic       w_win_live;
  logic       w_svc_end;

  assign w_eligible = DREQ & ~MASK;
  // Fixed mode always starts the search at ch0; the pointer is kept intact so
  // switching back to rotating mode resumes where rotation left off.
  assign w_base     = ROTATE ? r_prio_ptr : 2'd0;
  assign w_win_live = DREQ[r_winner] & ~MASK[r_winner];
  assign w_svc_end  = TC_DONE | ~HLDA;

  // Search the eligible set starting from the current top-priority channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_base + 2'(k);
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Arbitration/grant sequencer with registered bus-handshake outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_winner   <= 2'd0;
      r_prio_ptr <= 2'd0;
      r_gap_cnt  <= 4'd0;
      r_hrq      <= 1'b0;
      r_dack     <= 4'b0000;
      r_ch_valid <= 1'b0;
      r_ch_sel   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_pick;
            r_hrq    <= 1'b1;
            r_state  <= S_WAIT_HLDA;
          end
        end

        S_WAIT_HLDA: begin
          // A withdrawn or masked winner cancels the request outright, even
          // if HLDA arrives on the same edge; rotation is left untouched.
          if (!w_win_live) begin
            r_hrq   <= 1'b0;
            r_state <= S_IDLE;
          end else if (HLDA) begin
            r_dack     <= 4'b0001 << r_winner;
            r_ch_valid <= 1'b1;
            r_ch_sel   <= r_winner;
            r_state    <= S_SERVICE;
          end
        end

        S_SERVICE: begin
          if (w_svc_end) begin
            r_dack     <= 4'b0000;
            r_ch_valid <= 1'b0;
            r_ch_sel   <= 2'd0;
            r_hrq      <= 1'b0;
            r_gap_cnt  <= 4'(REARB_GAP - 1);
            r_state    <= S_GAP;
            if (ROTATE) begin
              r_prio_ptr <= r_winner + 2'd1;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_hrq      <= 1'b0;
          r_dack     <= 4'b0000;
          r_ch_valid <= 1'b0;
          r_ch_sel   <= 2'd0;
        end
      endcase
    end
  end

  assign HRQ      = r_hrq;
  assign DACK     = r_dack;
  assign CH_VALID = r_ch_valid;
  assign CH_SEL   = r_ch_sel;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios plus a randomized grant
// loop, all checked against a priority-list reference model.

module tb_dma_priority_arbiter;

  localparam int GAP = 2;

  logic       CLK;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] MASK;
  logic       ROTATE;
  logic       HLDA;
  logic       TC_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  logic       CH_VALID;
  logic [1:0] CH_SEL;

  int total;
  int bad;
  int m_ptr;
  bit mon_en;

  dma_priority_arbiter #(.REARB_GAP(GAP)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DREQ     (DREQ),
    .MASK     (MASK),
    .ROTATE   (ROTATE),
    .HLDA     (HLDA),
    .TC_DONE  (TC_DONE),
    .HRQ      (HRQ),
    .DACK     (DACK),
    .CH_VALID (CH_VALID),
    .CH_SEL   (CH_SEL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: walk the channels in priority order (top channel first) and
  // return the first requesting, unmasked one; -1 if none.
  function automatic int model_pick(bit [3:0] req, bit [3:0] msk, bit rot, int ptr);
    int order[4];
    for (int k = 0; k < 4; k++) order[k] = rot ? (ptr + k) % 4 : k;
    foreach (order[k]) if (req[order[k]] && !msk[order[k]]) return order[k];
    return -1;
  endfunction

  // Output-relationship checks that must hold in every cycle.
  always @(negedge CLK) begin
    if (mon_en && !RESET) begin
      total++;
      if (!(DACK inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) ||
          (CH_VALID !== (|DACK)) || ((DACK != 4'b0000) && (HRQ !== 1'b1)) ||
          (!CH_VALID && (CH_SEL != 2'd0))) begin
        bad++;
        $display("FAIL invariants dack=%b valid=%b hrq=%b sel=%0d", DACK, CH_VALID, HRQ, CH_SEL);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; DREQ = 4'b0; MASK = 4'b0; ROTATE = 1'b0; HLDA = 1'b0; TC_DONE = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    m_ptr = 0;
  endtask

  task automatic end_and_drain();
    TC_DONE = 1'b1;
    step();
    TC_DONE = 1'b0; HLDA = 1'b0; DREQ = 4'b0; MASK = 4'b0;
    repeat (GAP) step();
  endtask

  task automatic test_reset();
    RESET = 1'b1; DREQ = 4'hF; MASK = 4'b0; ROTATE = 1'b0; HLDA = 1'b1; TC_DONE = 1'b1;
    repeat (3) step();
    total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL reset_hrq got=%b exp=0", HRQ); end
    total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL reset_dack got=%b exp=0000", DACK); end
    total++; if (CH_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", CH_VALID); end
    total++; if (CH_SEL !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", CH_SEL); end
    HLDA = 1'b0; TC_DONE = 1'b0;
    RESET = 1'b0;
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL reset_first_arb hrq got=%b exp=1", HRQ); end
    do_reset();
  endtask

  task automatic test_fixed_basic();
    do_reset();
    DREQ = 4'b1010;
    total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL fixed_pre_hrq got=%b exp=0", HRQ); end
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL fixed_hrq got=%b exp=1", HRQ); end
    step();
    total++; if (DACK !== 4'b0000) begin bad++; $display("FAIL fixed_wait_dack got=%b exp=0000", DACK); end
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'(1 << model_pick(4'b1010, 4'b0, 1'b0, m_ptr)))
      begin bad++; $display("FAIL fixed_dack got=%b exp=0010", DACK); end
    total++; if (CH_SEL !== 2'd1) begin bad++; $display("FAIL fixed_sel got=%0d exp=1", CH_SEL); end
    TC_DONE = 1'b1;
    step();
    TC_DONE = 1'b0; HLDA = 1'b0;
    total++; if ({HRQ, DACK} !== 5'b0) begin bad++; $display("FAIL fixed_end hrq=%b dack=%b exp=0/0000", HRQ, DACK); end
    for (int i = 0; i < GAP; i++) begin
      step();
      total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL fixed_gap%0d hrq got=%b exp=0", i, HRQ); end
    end
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL fixed_rearb hrq got=%b exp=1", HRQ); end
    DREQ = 4'b0;
    step();
  endtask

  task automatic test_rotating();
    int n;
    int w;
    do_reset();
    ROTATE = 1'b1; DREQ = 4'hF; HLDA = 1'b1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin step(); n++; end while (DACK == 4'b0 && n < 20);
      w = model_pick(4'hF, 4'b0, 1'b1, m_ptr);
      total++; if (DACK !== 4'(1 << w)) begin bad++; $display("FAIL rot_grant%0d got=%b exp_ch=%0d", g, DACK, w); end
      if (g > 0) begin
        total++; if (n !== GAP + 2) begin bad++; $display("FAIL rot_spacing%0d got=%0d exp=%0d", g, n, GAP + 2); end
      end
      TC_DONE = 1'b1;
      step();
      TC_DONE = 1'b0;
      m_ptr = (w + 1) % 4;
      total++; if ({HRQ, DACK} !== 5'b0) begin bad++; $display("FAIL rot_end%0d hrq=%b dack=%b exp=0/0000", g, HRQ, DACK); end
    end
    HLDA = 1'b0; DREQ = 4'b0;
    repeat (GAP) step();
  endtask

  task automatic test_mask();
    do_reset();
    DREQ = 4'b0100; MASK = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL mask_blocked%0d hrq got=%b exp=0", i, HRQ); end
    end
    MASK = 4'b0;
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL mask_clear hrq got=%b exp=1", HRQ); end
    MASK = 4'b0100;
    step();
    total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL mask_rise hrq got=%b exp=0", HRQ); end
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'b0) begin bad++; $display("FAIL mask_idle_hlda dack got=%b exp=0000", DACK); end
    HLDA = 1'b0; DREQ = 4'b0; MASK = 4'b0;
    step();
  endtask

  task automatic test_withdraw();
    int w;
    do_reset();
    ROTATE = 1'b1; DREQ = 4'b0001;
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL wd_hrq got=%b exp=1", HRQ); end
    DREQ = 4'b0;
    step();
    total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL wd_drop hrq got=%b exp=0", HRQ); end
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'b0) begin bad++; $display("FAIL wd_hlda dack got=%b exp=0000", DACK); end
    HLDA = 1'b0;
    step();
    DREQ = 4'hF;
    step();
    HLDA = 1'b1;
    step();
    w = model_pick(4'hF, 4'b0, 1'b1, m_ptr);
    total++; if (DACK !== 4'(1 << w)) begin bad++; $display("FAIL wd_ptr dack got=%b exp_ch=%0d", DACK, w); end
    end_and_drain();
    m_ptr = (w + 1) % 4;
  endtask

  task automatic test_abort();
    do_reset();
    DREQ = 4'b1000;
    step();
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'b1000) begin bad++; $display("FAIL abort_grant dack got=%b exp=1000", DACK); end
    DREQ = 4'b0001; MASK = 4'b1000;
    step();
    total++; if (DACK !== 4'b1000) begin bad++; $display("FAIL abort_ignore dack got=%b exp=1000", DACK); end
    HLDA = 1'b0; DREQ = 4'b1000; MASK = 4'b0;
    step();
    total++; if ({HRQ, DACK} !== 5'b0) begin bad++; $display("FAIL abort_end hrq=%b dack=%b exp=0/0000", HRQ, DACK); end
    for (int i = 0; i < GAP; i++) begin
      step();
      total++; if (HRQ !== 1'b0) begin bad++; $display("FAIL abort_gap%0d hrq got=%b exp=0", i, HRQ); end
    end
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL abort_rearb hrq got=%b exp=1", HRQ); end
    DREQ = 4'b0;
    step();
  endtask

  task automatic test_random();
    bit [3:0] req;
    bit [3:0] msk;
    bit       rot;
    int       w;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      rot = 1'($urandom_range(0, 1));
      do begin
        req = 4'($urandom_range(0, 15));
        msk = 4'($urandom_range(0, 15));
      end while ((req & ~msk) == 4'b0);
      w = model_pick(req, msk, rot, m_ptr);
      ROTATE = rot; DREQ = req; MASK = msk;
      step();
      total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL rnd%0d_hrq got=%b exp=1", it, HRQ); end
      DREQ = 4'($urandom_range(0, 15)) | 4'(1 << w);
      MASK = 4'($urandom_range(0, 15)) & ~4'(1 << w);
      step();
      total++; if ({HRQ, DACK} !== 5'b10000) begin bad++; $display("FAIL rnd%0d_frozen hrq=%b dack=%b exp=1/0000", it, HRQ, DACK); end
      HLDA = 1'b1;
      step();
      total++; if (DACK !== 4'(1 << w) || CH_SEL !== 2'(w))
        begin bad++; $display("FAIL rnd%0d_grant dack=%b sel=%0d exp_ch=%0d", it, DACK, CH_SEL, w); end
      if ($urandom_range(0, 1) == 1) TC_DONE = 1'b1; else HLDA = 1'b0;
      DREQ = 4'($urandom_range(0, 15)); MASK = 4'($urandom_range(0, 15));
      step();
      total++; if ({HRQ, DACK} !== 5'b0) begin bad++; $display("FAIL rnd%0d_end hrq=%b dack=%b exp=0/0000", it, HRQ, DACK); end
      TC_DONE = 1'b0; HLDA = 1'b0; DREQ = 4'b0; MASK = 4'b0;
      if (rot) m_ptr = (w + 1) % 4;
      repeat (GAP) step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ROTATE = 1'b1; DREQ = 4'hF;
    step();
    HLDA = 1'b1;
    step();
    end_and_drain();
    m_ptr = 1;
    DREQ = 4'hF;
    step();
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'(1 << model_pick(4'hF, 4'b0, 1'b1, m_ptr)))
      begin bad++; $display("FAIL ares_pre dack got=%b exp=0010", DACK); end
    #2;
    RESET = 1'b1;
    #1;
    total++; if ({HRQ, DACK, CH_VALID} !== 6'b0)
      begin bad++; $display("FAIL ares_async hrq=%b dack=%b valid=%b exp=0/0000/0", HRQ, DACK, CH_VALID); end
    step();
    step();
    HLDA = 1'b0; DREQ = 4'hF; ROTATE = 1'b1;
    #2;
    RESET = 1'b0;
    m_ptr = 0;
    step();
    total++; if (HRQ !== 1'b1) begin bad++; $display("FAIL ares_first_arb hrq got=%b exp=1", HRQ); end
    HLDA = 1'b1;
    step();
    total++; if (DACK !== 4'(1 << model_pick(4'hF, 4'b0, 1'b1, m_ptr)))
      begin bad++; $display("FAIL ares_restart dack got=%b exp=0001", DACK); end
    end_and_drain();
  endtask

  initial begin
    total = 0; bad = 0; m_ptr = 0; mon_en = 1'b0;
    RESET = 1'b1; DREQ = 4'b0; MASK = 4'b0; ROTATE = 1'b0; HLDA = 1'b0; TC_DONE = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_fixed_basic();
    test_rotating();
    test_mask();
    test_withdraw();
    test_abort();
    test_random();
    test_async_reset();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
